// File: rtl/fft_seq_pkg.sv
// fft_seq_pkg
// Shared types and width helpers for the FFT frame sequencer.
//   seq_state_t  : transform FSM states
//   DEF_*        : default frame length and output-strobe timeout
//   *_width()    : counter/index widths derived from the frame length
package fft_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KICK,
        FEED,
        WAIT_OUT,
        DRAIN
    } seq_state_t;

    localparam int DEF_N_POINTS       = 512;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    // Sample counter across one whole frame (both banks).
    function automatic int fill_width(input int n_points);
        return $clog2(n_points);
    endfunction

    // Pair index across one bank / one output frame.
    function automatic int bin_width(input int n_points);
        return $clog2(n_points / 2);
    endfunction

    // The FSM cycle counter is shared by FEED, WAIT_OUT and DRAIN, so it must
    // cover the larger of a bank length and the timeout.
    function automatic int cnt_width(input int n_points, input int timeout_cycles);
        int longest;
        longest = (n_points / 2 > timeout_cycles) ? n_points / 2 : timeout_cycles;
        return $clog2(longest) + 1;
    endfunction

endpackage

// File: rtl/pingpong_fill_ctr.sv
// pingpong_fill_ctr
// Steers accepted samples alternately into the even/odd sample banks and
// flags when a complete frame is buffered.
// Ports:
//   clk, reset    : system clock, synchronous active-high reset
//   sample_valid  : one-cycle strobe per incoming audio sample
//   consume       : one-cycle pulse from the transform FSM taking the frame
//   wr_en[1:0]    : registered bank write enables ([0] even, [1] odd)
//   frame_ready   : a full frame is waiting to be transformed
//   overrun       : sticky, a sample arrived while a frame was still waiting
module pingpong_fill_ctr
    import fft_seq_pkg::*;
#(
    parameter int N_POINTS = DEF_N_POINTS
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_valid,
    input  logic       consume,
    output logic [1:0] wr_en,
    output logic       frame_ready,
    output logic       overrun
);

    localparam int FILL_W = fill_width(N_POINTS);
    localparam logic [FILL_W-1:0] LAST_IDX = FILL_W'(N_POINTS - 1);

    logic [FILL_W-1:0] fill_cnt;
    logic              sel;
    logic              accept;

    // Samples are only taken while no finished frame is pending; the registered
    // frame_ready is used, so a sample landing in the KICK cycle is still dropped.
    assign accept = sample_valid && !frame_ready;

    // Fill bookkeeping: the write enable is registered, so it trails the accepted
    // strobe by one cycle. fill_cnt wraps naturally because N_POINTS is a power of 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_cnt    <= '0;
            sel         <= 1'b0;
            frame_ready <= 1'b0;
            overrun     <= 1'b0;
            wr_en       <= '0;
        end else begin
            wr_en <= '0;
            if (accept) begin
                wr_en    <= sel ? 2'b10 : 2'b01;
                sel      <= ~sel;
                fill_cnt <= fill_cnt + FILL_W'(1);
                if (fill_cnt == LAST_IDX) begin
                    frame_ready <= 1'b1;
                end
            end
            if (consume) begin
                frame_ready <= 1'b0;
            end
            if (sample_valid && frame_ready) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer
// Sequences the audio spectrum datapath: fills two sample banks in ping-pong
// fashion, kicks the streaming DFT core once a frame is buffered, drains both
// banks into it and frames the returned bin pairs for the peak detector.
// Ports:
//   clk, reset    : 50 MHz system clock, synchronous active-high reset
//   sample_valid  : one-cycle strobe per new audio sample
//   wr_en[1:0]    : bank write enables ([0] even samples, [1] odd samples)
//   rd_en         : read request to both banks
//   fft_reset     : reset to the DFT core (high in reset and after a timeout)
//   fft_next      : one-cycle frame-start pulse to the core
//   fft_next_out  : core strobe, one cycle before its first output pair
//   max_clear     : one-cycle pulse restarting the peak detector
//   bin_valid     : an output bin pair is present
//   bin_index     : pair index of the current output
//   frame_done    : pulses with the last bin pair
//   overrun       : sticky, a sample was dropped
//   fft_error     : sticky, the core's output strobe timed out
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int N_POINTS       = DEF_N_POINTS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
)
(
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            sample_valid,
    output logic [1:0]                      wr_en,
    output logic                            rd_en,
    output logic                            fft_reset,
    output logic                            fft_next,
    input  logic                            fft_next_out,
    output logic                            max_clear,
    output logic                            bin_valid,
    output logic [bin_width(N_POINTS)-1:0]  bin_index,
    output logic                            frame_done,
    output logic                            overrun,
    output logic                            fft_error
);

    localparam int BIN_W = bin_width(N_POINTS);
    localparam int CNT_W = cnt_width(N_POINTS, TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(N_POINTS / 2 - 2);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(N_POINTS / 2 - 1);

    seq_state_t        state;
    seq_state_t        next_state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              frame_ready;
    logic              timeout;

    logic              fft_next_d;
    logic              rd_en_d;
    logic              max_clear_d;
    logic              bin_valid_d;
    logic [BIN_W-1:0]  bin_index_d;
    logic              frame_done_d;
    logic              fft_reset_d;

    pingpong_fill_ctr #(
        .N_POINTS (N_POINTS)
    ) u_fill (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .consume      (state == KICK),
        .wr_en        (wr_en),
        .frame_ready  (frame_ready),
        .overrun      (overrun)
    );

    // State register plus output registers. Outputs are decoded from the next
    // state, so each registered output lines up with the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            fft_reset  <= 1'b1;
            fft_next   <= 1'b0;
            rd_en      <= 1'b0;
            max_clear  <= 1'b0;
            bin_valid  <= 1'b0;
            bin_index  <= '0;
            frame_done <= 1'b0;
            fft_error  <= 1'b0;
        end else begin
            state      <= next_state;
            cnt        <= cnt_next;
            fft_reset  <= fft_reset_d;
            fft_next   <= fft_next_d;
            rd_en      <= rd_en_d;
            max_clear  <= max_clear_d;
            bin_valid  <= bin_valid_d;
            bin_index  <= bin_index_d;
            frame_done <= frame_done_d;
            if (timeout) begin
                fft_error <= 1'b1;
            end
        end
    end

    // Next-state logic. cnt counts cycles spent in the current state and
    // restarts on every transition; KICK supplies the first of the N/2 reads,
    // so FEED only needs N/2-1. A strobe on the final WAIT_OUT cycle still wins
    // over the timeout.
    always_comb begin
        next_state = state;
        timeout    = 1'b0;
        unique case (state)
            IDLE:     if (frame_ready) next_state = KICK;
            KICK:     next_state = FEED;
            FEED:     if (cnt == FEED_LAST) next_state = WAIT_OUT;
            WAIT_OUT: begin
                if (fft_next_out) begin
                    next_state = DRAIN;
                end else if (cnt == WAIT_LAST) begin
                    next_state = IDLE;
                    timeout    = 1'b1;
                end
            end
            DRAIN:    if (cnt == DRAIN_LAST) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
        cnt_next = (next_state != state || state == IDLE) ? '0 : cnt + CNT_W'(1);
    end

    // Output decode for the following cycle. max_clear coincides with bin 0 so
    // the detector restarts on the first pair of the new frame.
    always_comb begin
        fft_next_d   = (next_state == KICK);
        rd_en_d      = (next_state == KICK) || (next_state == FEED);
        max_clear_d  = (state == WAIT_OUT) && (next_state == DRAIN);
        bin_valid_d  = (next_state == DRAIN);
        bin_index_d  = bin_valid_d ? cnt_next[BIN_W-1:0] : '0;
        frame_done_d = bin_valid_d && (cnt_next == DRAIN_LAST);
        fft_reset_d  = timeout;
    end

endmodule
